line_bresenham_stepper: RTL and testbench
=========================================

LINE_BRESENHAM_STEPPER -- requirements
Module: line_bresenham_stepper

Interface
REQ-001 Parameter WIDTH SHALL default to 13 and set the coordinate width for all coordinate ports.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle line request; sampled only in IDLE.
REQ-005 x0, y0, x1, y1  input  WIDTH each  unsigned endpoint coordinates, sampled when start is accepted.
REQ-006 pix_ready  input  1  downstream FB address generator can accept a pixel.
REQ-007 pix_valid  output  1  x_coord/y_coord/steep carry a pixel; drives the FB address generator enable.
REQ-008 steep  output  1  pixel coordinates are axis-swapped (|dy|>|dx|).
REQ-009 x_coord, y_coord  output  WIDTH each  pixel coordinates in swapped space when steep=1.
REQ-010 busy  output  1  line in progress; done  output  1  one-cycle pulse after the last pixel transfers.

Function
REQ-011 The FSM SHALL have states IDLE, SETUP, INIT, STEP, DONE.
REQ-012 IDLE->SETUP on start; start while not IDLE SHALL be ignored.
REQ-013 SETUP: steep=(|y1-y0|>|x1-x0|); if steep, swap x and y of both endpoints; then if xa>xb, swap endpoints.
REQ-014 INIT: dx=xb-xa, dy=|yb-ya|, err=dx>>1, ystep=+1 if ya<yb else -1; x=xa, y=ya.
REQ-015 err SHALL be a signed register of WIDTH+2 bits; dx, dy SHALL be WIDTH+1 bits; no overflow for any legal input.
REQ-016 STEP: pix_valid=1 with (x,y); a transfer occurs when pix_valid and pix_ready are both high in a cycle.
REQ-017 On transfer: if x==xb go to DONE; else x+=1, err-=dy, and if the new err<0 then y+=ystep and err+=dx, all in the same cycle.
REQ-018 Without a transfer, x_coord, y_coord, steep and pix_valid SHALL hold unchanged.
REQ-019 First pixel_valid SHALL appear 3 cycles after the start cycle (SETUP, INIT, then STEP); throughput one pixel/cycle with pix_ready high.
REQ-020 Pixel count SHALL equal max(|x1-x0|,|y1-y0|)+1; a zero-length line (x0==x1, y0==y1) SHALL emit exactly one pixel with steep=0.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in SETUP, INIT, STEP and DONE.

Reset
REQ-022 On rst: state=IDLE; pix_valid, busy, done, steep = 0; x_coord, y_coord = 0; internal err, dx, dy = 0.
REQ-023 rst asserted mid-line SHALL abort the line immediately; no further pixels and no done pulse.

Configuration
REQ-024 Macro LINE_SCREEN_CLIP_EN: when defined, pixels whose screen position (x,y, or y,x when steep) falls outside 640x480 SHALL not assert pix_valid; the stepper SHALL advance through them at one per cycle regardless of pix_ready.
REQ-025 Without LINE_SCREEN_CLIP_EN, every computed pixel SHALL be presented and SHALL wait for pix_ready.
REQ-026 Clipping SHALL NOT affect done; done fires after the final computed pixel whether or not it was presented.

Structure
REQ-027 Shared package line_pkg SHALL hold WIDTH default, SCREEN_W=640, SCREEN_H=480 and the FSM state typedef.
REQ-028 Sub-module line_setup SHALL hold the combinational steep/swap/delta logic for SETUP and INIT; the stepping FSM stays in the top module.

Verification
REQ-029 (0,0)->(3,0), pix_ready=1: pixels (0,0),(1,0),(2,0),(3,0), steep=0, first pix_valid at cycle 3, done at cycle 7.
REQ-030 (2,1)->(2,5): steep=1, x_coord 1..5, y_coord=2 constant, 5 pixels.
REQ-031 (5,3)->(1,1): endpoints swapped; pixels (1,1),(2,1),(3,2),(4,2),(5,3), steep=0.
REQ-032 (0,0)->(3,3) with pix_ready low for 3 cycles on the 2nd pixel: (1,1) is held stable for 4 cycles, no pixel lost or duplicated.
REQ-033 rst pulsed during the 3rd pixel of (0,0)->(9,0): all outputs 0 next cycle, no done; a new start then completes normally.
REQ-034 With LINE_SCREEN_CLIP_EN, (630,0)->(645,0): exactly 10 pixels presented (x=630..639); done asserted after 16 computed pixels.

Source files
------------

// File: rtl/line_pkg.sv
// Shared definitions for the Bresenham line stepper: default coordinate
// width, screen dimensions used by the optional clip stage, and the FSM
// state type.
package line_pkg;

  localparam int WIDTH_DEFAULT = 13;

  localparam logic [31:0] SCREEN_W = 32'd640;
  localparam logic [31:0] SCREEN_H = 32'd480;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_INIT  = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } line_state_t;

  // True when a screen position lies inside the visible raster.
  function automatic logic on_screen(input logic [31:0] sx, input logic [31:0] sy);
    return (sx < SCREEN_W) && (sy < SCREEN_H);
  endfunction

endpackage

// File: rtl/line_setup.sv
// Combinational helpers for the line stepper.
//  - Setup half: decides whether the line is steep, swaps x/y of both
//    endpoints when it is, then orders the endpoints so xa <= xb.
//  - Delta half: from the ordered endpoints derives dx, |dy| and the
//    direction of the minor axis.
// The two halves are used in different FSM cycles, so they take separate
// (registered) inputs.
module line_setup
  import line_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             steep,
  output logic [WIDTH-1:0] xa,
  output logic [WIDTH-1:0] ya,
  output logic [WIDTH-1:0] xb,
  output logic [WIDTH-1:0] yb,
  input  logic [WIDTH-1:0] sxa,
  input  logic [WIDTH-1:0] sya,
  input  logic [WIDTH-1:0] sxb,
  input  logic [WIDTH-1:0] syb,
  output logic [WIDTH:0]   dx,
  output logic [WIDTH:0]   dy,
  output logic             ystep_neg
);

  logic [WIDTH-1:0] adx;
  logic [WIDTH-1:0] ady;
  logic [WIDTH-1:0] pxa;
  logic [WIDTH-1:0] pya;
  logic [WIDTH-1:0] pxb;
  logic [WIDTH-1:0] pyb;

  // Steepness test, optional axis swap, then endpoint ordering along x.
  always_comb begin
    adx   = '0;
    ady   = '0;
    pxa   = x0;
    pya   = y0;
    pxb   = x1;
    pyb   = y1;
    steep = 1'b0;
    xa    = x0;
    ya    = y0;
    xb    = x1;
    yb    = y1;

    if (x1 >= x0) begin
      adx = x1 - x0;
    end else begin
      adx = x0 - x1;
    end

    if (y1 >= y0) begin
      ady = y1 - y0;
    end else begin
      ady = y0 - y1;
    end

    steep = (ady > adx);

    if (steep) begin
      pxa = y0;
      pya = x0;
      pxb = y1;
      pyb = x1;
    end else begin
      pxa = x0;
      pya = y0;
      pxb = x1;
      pyb = y1;
    end

    if (pxa > pxb) begin
      xa = pxb;
      ya = pyb;
      xb = pxa;
      yb = pya;
    end else begin
      xa = pxa;
      ya = pya;
      xb = pxb;
      yb = pyb;
    end
  end

  // Deltas of the ordered line; sxb >= sxa always holds here.
  always_comb begin
    dx        = {1'b0, sxb} - {1'b0, sxa};
    dy        = '0;
    ystep_neg = 1'b0;
    if (sya < syb) begin
      dy        = {1'b0, syb} - {1'b0, sya};
      ystep_neg = 1'b0;
    end else begin
      dy        = {1'b0, sya} - {1'b0, syb};
      ystep_neg = 1'b1;
    end
  end

endmodule

// File: rtl/line_bresenham_stepper.sv
// Bresenham line stepper: accepts a pair of endpoints and emits one pixel per
// cycle over a valid/ready handshake toward the frame-buffer address
// generator. Coordinates are presented in swapped (y,x) space when steep=1.
// Optional build macro LINE_SCREEN_CLIP_EN suppresses pix_valid for pixels
// outside the 640x480 screen; such pixels are stepped over without waiting
// for pix_ready.
module line_bresenham_stepper
  import line_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic             pix_ready,
  output logic             pix_valid,
  output logic             steep,
  output logic [WIDTH-1:0] x_coord,
  output logic [WIDTH-1:0] y_coord,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  line_state_t state_r, state_nxt;

  // latched request
  logic [WIDTH-1:0] rx0_r, ry0_r, rx1_r, ry1_r;
  logic [WIDTH-1:0] rx0_nxt, ry0_nxt, rx1_nxt, ry1_nxt;
  // ordered endpoints from SETUP
  logic [WIDTH-1:0] xa_r, ya_r, xb_r, yb_r;
  logic [WIDTH-1:0] xa_nxt, ya_nxt, xb_nxt, yb_nxt;
  logic             steep_int_r, steep_int_nxt;
  // stepping state
  logic [WIDTH:0]          dx_r, dy_r, dx_nxt, dy_nxt;
  logic signed [WIDTH+1:0] err_r, err_nxt;
  logic                    ystep_neg_r, ystep_neg_nxt;
  logic [WIDTH-1:0]        x_r, y_r, x_nxt, y_nxt;
  logic                    steep_r, steep_nxt;
  logic                    pix_valid_r, pix_valid_nxt;
  logic                    busy_r, busy_nxt;
  logic                    done_r, done_nxt;

  // setup helper outputs
  logic             s_steep;
  logic [WIDTH-1:0] s_xa, s_ya, s_xb, s_yb;
  logic [WIDTH:0]   s_dx, s_dy;
  logic             s_ystep_neg;

  // stepping arithmetic
  logic                    advance;
  logic signed [WIDTH+1:0] err_sub;
  logic signed [WIDTH+1:0] err_add;
  logic [WIDTH-1:0]        x_adv;
  logic [WIDTH-1:0]        y_adv;
  logic signed [WIDTH+1:0] err_adv;

  line_setup #(.WIDTH(WIDTH)) u_setup (
    .x0        (rx0_r),
    .y0        (ry0_r),
    .x1        (rx1_r),
    .y1        (ry1_r),
    .steep     (s_steep),
    .xa        (s_xa),
    .ya        (s_ya),
    .xb        (s_xb),
    .yb        (s_yb),
    .sxa       (xa_r),
    .sya       (ya_r),
    .sxb       (xb_r),
    .syb       (yb_r),
    .dx        (s_dx),
    .dy        (s_dy),
    .ystep_neg (s_ystep_neg)
  );

`ifdef LINE_SCREEN_CLIP_EN
  // Pixel visibility in screen space (axes swapped back when steep).
  function automatic logic pix_visible(input logic [WIDTH-1:0] px,
                                       input logic [WIDTH-1:0] py,
                                       input logic             pst);
    logic [31:0] sx;
    logic [31:0] sy;
    if (pst) begin
      sx = 32'(py);
      sy = 32'(px);
    end else begin
      sx = 32'(px);
      sy = 32'(py);
    end
    return on_screen(sx, sy);
  endfunction
`endif

  // Next Bresenham point: x+1, err-=dy, and a minor-axis step when err < 0.
  always_comb begin
    err_sub = err_r - $signed({1'b0, dy_r});
    err_add = err_sub + $signed({1'b0, dx_r});
    x_adv   = x_r + ONE;
    y_adv   = y_r;
    err_adv = err_sub;
    if (err_sub < 0) begin
      err_adv = err_add;
      if (ystep_neg_r) begin
        y_adv = y_r - ONE;
      end else begin
        y_adv = y_r + ONE;
      end
    end else begin
      err_adv = err_sub;
      y_adv   = y_r;
    end
  end

  // Whether the current pixel is consumed this cycle.
  always_comb begin
`ifdef LINE_SCREEN_CLIP_EN
    if (pix_valid_r) begin
      advance = pix_ready;
    end else begin
      advance = 1'b1;
    end
`else
    advance = pix_valid_r & pix_ready;
`endif
  end

  // FSM next-state and next values for every register.
  always_comb begin
    state_nxt     = state_r;
    rx0_nxt       = rx0_r;
    ry0_nxt       = ry0_r;
    rx1_nxt       = rx1_r;
    ry1_nxt       = ry1_r;
    xa_nxt        = xa_r;
    ya_nxt        = ya_r;
    xb_nxt        = xb_r;
    yb_nxt        = yb_r;
    steep_int_nxt = steep_int_r;
    dx_nxt        = dx_r;
    dy_nxt        = dy_r;
    err_nxt       = err_r;
    ystep_neg_nxt = ystep_neg_r;
    x_nxt         = x_r;
    y_nxt         = y_r;
    steep_nxt     = steep_r;
    pix_valid_nxt = pix_valid_r;
    busy_nxt      = busy_r;
    done_nxt      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          rx0_nxt   = x0;
          ry0_nxt   = y0;
          rx1_nxt   = x1;
          ry1_nxt   = y1;
          busy_nxt  = 1'b1;
          state_nxt = ST_SETUP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        steep_int_nxt = s_steep;
        xa_nxt        = s_xa;
        ya_nxt        = s_ya;
        xb_nxt        = s_xb;
        yb_nxt        = s_yb;
        state_nxt     = ST_INIT;
      end
      ST_INIT: begin
        dx_nxt        = s_dx;
        dy_nxt        = s_dy;
        err_nxt       = $signed({2'b00, s_dx[WIDTH:1]});
        ystep_neg_nxt = s_ystep_neg;
        x_nxt         = xa_r;
        y_nxt         = ya_r;
        steep_nxt     = steep_int_r;
`ifdef LINE_SCREEN_CLIP_EN
        pix_valid_nxt = pix_visible(xa_r, ya_r, steep_int_r);
`else
        pix_valid_nxt = 1'b1;
`endif
        state_nxt     = ST_STEP;
      end
      ST_STEP: begin
        if (advance) begin
          if (x_r == xb_r) begin
            pix_valid_nxt = 1'b0;
            done_nxt      = 1'b1;
            state_nxt     = ST_DONE;
          end else begin
            x_nxt         = x_adv;
            y_nxt         = y_adv;
            err_nxt       = err_adv;
`ifdef LINE_SCREEN_CLIP_EN
            pix_valid_nxt = pix_visible(x_adv, y_adv, steep_r);
`else
            pix_valid_nxt = 1'b1;
`endif
            state_nxt     = ST_STEP;
          end
        end else begin
          state_nxt = ST_STEP;
        end
      end
      ST_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        pix_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
        state_nxt     = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx0_r       <= '0;
      ry0_r       <= '0;
      rx1_r       <= '0;
      ry1_r       <= '0;
      xa_r        <= '0;
      ya_r        <= '0;
      xb_r        <= '0;
      yb_r        <= '0;
      steep_int_r <= 1'b0;
      dx_r        <= '0;
      dy_r        <= '0;
      err_r       <= '0;
      ystep_neg_r <= 1'b0;
      x_r         <= '0;
      y_r         <= '0;
      steep_r     <= 1'b0;
      pix_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      rx0_r       <= rx0_nxt;
      ry0_r       <= ry0_nxt;
      rx1_r       <= rx1_nxt;
      ry1_r       <= ry1_nxt;
      xa_r        <= xa_nxt;
      ya_r        <= ya_nxt;
      xb_r        <= xb_nxt;
      yb_r        <= yb_nxt;
      steep_int_r <= steep_int_nxt;
      dx_r        <= dx_nxt;
      dy_r        <= dy_nxt;
      err_r       <= err_nxt;
      ystep_neg_r <= ystep_neg_nxt;
      x_r         <= x_nxt;
      y_r         <= y_nxt;
      steep_r     <= steep_nxt;
      pix_valid_r <= pix_valid_nxt;
      busy_r      <= busy_nxt;
      done_r      <= done_nxt;
    end
  end

  assign pix_valid = pix_valid_r;
  assign steep     = steep_r;
  assign x_coord   = x_r;
  assign y_coord   = y_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_line_bresenham_stepper.sv
// Directed bench for line_bresenham_stepper. Expected pixel lists are worked
// out by hand from the Bresenham recurrence. The clip scenario only runs when
// the bench is built with LINE_SCREEN_CLIP_EN.
module tb_line_bresenham_stepper;

  localparam int W = 13;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] x0, y0, x1, y1;
  logic         pix_ready;
  logic         pix_valid;
  logic         steep;
  logic [W-1:0] x_coord, y_coord;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  int px_q[$];
  int py_q[$];
  int st_q[$];

  line_bresenham_stepper #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .pix_ready (pix_ready),
    .pix_valid (pix_valid),
    .steep     (steep),
    .x_coord   (x_coord),
    .y_coord   (y_coord),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one line with pix_ready held high and record every presented pixel.
  // Cycle 0 is the start cycle. done_cyc stays -1 if the budget runs out.
  task automatic collect_line(input int ax0, input int ay0, input int ax1, input int ay1,
                              input int spur, output int first_cyc, output int done_cyc);
    logic [W-1:0] t;
    px_q.delete();
    py_q.delete();
    st_q.delete();
    first_cyc = -1;
    done_cyc  = -1;
    t = ax0[W-1:0]; x0 = t;
    t = ay0[W-1:0]; y0 = t;
    t = ax1[W-1:0]; x1 = t;
    t = ay1[W-1:0]; y1 = t;
    pix_ready = 1'b1;
    start     = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      start = 1'b0;
      t = ax0[W-1:0]; x0 = t;
      t = ay0[W-1:0]; y0 = t;
      if (c == spur) begin
        start = 1'b1;
        x0    = 13'd100;
        y0    = 13'd100;
      end
      if (pix_valid) begin
        px_q.push_back(int'(x_coord));
        py_q.push_back(int'(y_coord));
        st_q.push_back(int'(steep));
        if (first_cyc < 0) first_cyc = c;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    tick(); tick();
    checks++;
    if ({pix_valid, busy, done, steep} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000", {pix_valid, busy, done, steep});
    end
    checks++;
    if (x_coord !== 13'd0 || y_coord !== 13'd0) begin
      errors++;
      $display("FAIL reset_coords: got (%0d,%0d) required (0,0)", x_coord, y_coord);
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b pix_valid=%b required 0 0", busy, pix_valid);
    end
  endtask

  task automatic test_horizontal;
    int f, d;
    collect_line(0, 0, 3, 0, -1, f, d);
    checks++;
    if (px_q.size() !== 4) begin
      errors++;
      $display("FAIL horiz_count: got %0d required 4", px_q.size());
    end
    for (int i = 0; i < px_q.size() && i < 4; i++) begin
      checks++;
      if (px_q[i] !== i || py_q[i] !== 0 || st_q[i] !== 0) begin
        errors++;
        $display("FAIL horiz_pix%0d: got (%0d,%0d,s%0d) required (%0d,0,s0)", i, px_q[i], py_q[i], st_q[i], i);
      end
    end
    checks++;
    if (f !== 3) begin
      errors++;
      $display("FAIL horiz_first_cycle: got %0d required 3", f);
    end
    checks++;
    if (d !== 7) begin
      errors++;
      $display("FAIL horiz_done_cycle: got %0d required 7", d);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL horiz_done_pulse: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_steep;
    int f, d;
    int ex[5] = '{0, 1, 2, 3, 4};
    int ey[5] = '{2, 2, 1, 1, 0};
    collect_line(2, 1, 2, 5, -1, f, d);
    tick();
    checks++;
    if (px_q.size() !== 5) begin
      errors++;
      $display("FAIL steep_vert_count: got %0d required 5", px_q.size());
    end
    for (int i = 0; i < px_q.size() && i < 5; i++) begin
      checks++;
      if (px_q[i] !== i + 1 || py_q[i] !== 2 || st_q[i] !== 1) begin
        errors++;
        $display("FAIL steep_vert_pix%0d: got (%0d,%0d,s%0d) required (%0d,2,s1)", i, px_q[i], py_q[i], st_q[i], i + 1);
      end
    end
    // (0,4)->(2,0): steep, endpoints reordered, minor axis steps downward
    collect_line(0, 4, 2, 0, -1, f, d);
    tick();
    checks++;
    if (px_q.size() !== 5) begin
      errors++;
      $display("FAIL steep_desc_count: got %0d required 5", px_q.size());
    end
    for (int i = 0; i < px_q.size() && i < 5; i++) begin
      checks++;
      if (px_q[i] !== ex[i] || py_q[i] !== ey[i] || st_q[i] !== 1) begin
        errors++;
        $display("FAIL steep_desc_pix%0d: got (%0d,%0d,s%0d) required (%0d,%0d,s1)", i, px_q[i], py_q[i], st_q[i], ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_swap;
    int f, d;
    int ex[5] = '{1, 2, 3, 4, 5};
    int ey[5] = '{1, 1, 2, 2, 3};
    collect_line(5, 3, 1, 1, -1, f, d);
    tick();
    checks++;
    if (px_q.size() !== 5) begin
      errors++;
      $display("FAIL swap_count: got %0d required 5", px_q.size());
    end
    for (int i = 0; i < px_q.size() && i < 5; i++) begin
      checks++;
      if (px_q[i] !== ex[i] || py_q[i] !== ey[i] || st_q[i] !== 0) begin
        errors++;
        $display("FAIL swap_pix%0d: got (%0d,%0d,s%0d) required (%0d,%0d,s0)", i, px_q[i], py_q[i], st_q[i], ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_zero_length;
    int f, d;
    collect_line(7, 7, 7, 7, -1, f, d);
    tick();
    checks++;
    if (px_q.size() !== 1) begin
      errors++;
      $display("FAIL zero_count: got %0d required 1", px_q.size());
    end else if (px_q[0] !== 7 || py_q[0] !== 7 || st_q[0] !== 0) begin
      errors++;
      $display("FAIL zero_pix: got (%0d,%0d,s%0d) required (7,7,s0)", px_q[0], py_q[0], st_q[0]);
    end
    checks++;
    if (d !== 4) begin
      errors++;
      $display("FAIL zero_done_cycle: got %0d required 4", d);
    end
  endtask

  task automatic test_stall;
    int hold;
    x0 = 13'd0; y0 = 13'd0; x1 = 13'd3; y1 = 13'd3;
    pix_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++;
    if (pix_valid !== 1'b1 || x_coord !== 13'd0 || y_coord !== 13'd0) begin
      errors++;
      $display("FAIL stall_pix0: got v%b (%0d,%0d) required v1 (0,0)", pix_valid, x_coord, y_coord);
    end
    tick();
    pix_ready = 1'b0;
    hold = 0;
    for (int k = 0; k < 3; k++) begin
      if (pix_valid === 1'b1 && x_coord === 13'd1 && y_coord === 13'd1) hold++;
      tick();
    end
    if (pix_valid === 1'b1 && x_coord === 13'd1 && y_coord === 13'd1) hold++;
    pix_ready = 1'b1;
    checks++;
    if (hold !== 4) begin
      errors++;
      $display("FAIL stall_hold: got %0d cycles of (1,1) required 4", hold);
    end
    tick();
    checks++;
    if (pix_valid !== 1'b1 || x_coord !== 13'd2 || y_coord !== 13'd2) begin
      errors++;
      $display("FAIL stall_pix2: got v%b (%0d,%0d) required v1 (2,2)", pix_valid, x_coord, y_coord);
    end
    tick();
    checks++;
    if (pix_valid !== 1'b1 || x_coord !== 13'd3 || y_coord !== 13'd3) begin
      errors++;
      $display("FAIL stall_pix3: got v%b (%0d,%0d) required v1 (3,3)", pix_valid, x_coord, y_coord);
    end
    tick();
    checks++;
    if (done !== 1'b1 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: done=%b pix_valid=%b required 1 0", done, pix_valid);
    end
    tick();
  endtask

  task automatic test_reset_midline;
    int seen, f, d;
    x0 = 13'd0; y0 = 13'd0; x1 = 13'd9; y1 = 13'd0;
    pix_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if (pix_valid !== 1'b1 || x_coord !== 13'd2) begin
      errors++;
      $display("FAIL midrst_pre: got v%b x=%0d required v1 x=2", pix_valid, x_coord);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({pix_valid, busy, done, steep} !== 4'b0000 || x_coord !== 13'd0 || y_coord !== 13'd0) begin
      errors++;
      $display("FAIL midrst_outputs: flags=%b (%0d,%0d) required 0000 (0,0)", {pix_valid, busy, done, steep}, x_coord, y_coord);
    end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (pix_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrst_abort: got %0d active cycles required 0", seen);
    end
    collect_line(0, 0, 2, 0, -1, f, d);
    tick();
    checks++;
    if (px_q.size() !== 3 || f !== 3 || d !== 6) begin
      errors++;
      $display("FAIL midrst_restart: got count=%0d first=%0d done=%0d required 3 3 6", px_q.size(), f, d);
    end
  endtask

  task automatic test_ignore_start;
    int f, d;
    int ex[5] = '{0, 1, 2, 3, 4};
    int ey[5] = '{0, 0, 1, 1, 2};
    collect_line(0, 0, 4, 2, 4, f, d);
    checks++;
    if (d !== 8 || px_q.size() !== 5) begin
      errors++;
      $display("FAIL ignore_start_len: got done=%0d count=%0d required 8 5", d, px_q.size());
    end
    for (int i = 0; i < px_q.size() && i < 5; i++) begin
      checks++;
      if (px_q[i] !== ex[i] || py_q[i] !== ey[i]) begin
        errors++;
        $display("FAIL ignore_start_pix%0d: got (%0d,%0d) required (%0d,%0d)", i, px_q[i], py_q[i], ex[i], ey[i]);
      end
    end
    tick(); tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int f, d;
    int ex[3] = '{10, 11, 12};
    int ey[3] = '{20, 20, 21};
    collect_line(1, 1, 2, 1, -1, f, d);
    tick();
    collect_line(10, 20, 12, 21, -1, f, d);
    tick();
    checks++;
    if (f !== 3 || d !== 6 || px_q.size() !== 3) begin
      errors++;
      $display("FAIL b2b_timing: got first=%0d done=%0d count=%0d required 3 6 3", f, d, px_q.size());
    end
    for (int i = 0; i < px_q.size() && i < 3; i++) begin
      checks++;
      if (px_q[i] !== ex[i] || py_q[i] !== ey[i]) begin
        errors++;
        $display("FAIL b2b_pix%0d: got (%0d,%0d) required (%0d,%0d)", i, px_q[i], py_q[i], ex[i], ey[i]);
      end
    end
  endtask

`ifdef LINE_SCREEN_CLIP_EN
  task automatic test_clip;
    int f, d;
    collect_line(630, 0, 645, 0, -1, f, d);
    tick();
    checks++;
    if (px_q.size() !== 10) begin
      errors++;
      $display("FAIL clip_count: got %0d required 10", px_q.size());
    end
    for (int i = 0; i < px_q.size() && i < 10; i++) begin
      checks++;
      if (px_q[i] !== 630 + i) begin
        errors++;
        $display("FAIL clip_pix%0d: got x=%0d required %0d", i, px_q[i], 630 + i);
      end
    end
    checks++;
    if (d !== 19) begin
      errors++;
      $display("FAIL clip_done_cycle: got %0d required 19", d);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_horizontal();
    test_steep();
    test_swap();
    test_zero_length();
    test_stall();
    test_reset_midline();
    test_ignore_start();
    test_back_to_back();
`ifdef LINE_SCREEN_CLIP_EN
    test_clip();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
